cycle_sequencer: RTL and testbench

- Parametrised replacement for the fixed four-beat timing generator in the control unit.
- Sequences each instruction through three machine cycles:
  - IF (fetch), always.
  - EX (execute), always.
  - MEM (memory), only when needed.
- The beat count of each cycle is set per instruction, up to `T_MAX`.
- Bus handshakes stall the sequence, and a stop request halts it cleanly.
- Emits one-hot machine-cycle and beat strobes plus an end-of-instruction pulse; decode logic in the control unit gates register, PC, ALU and bus controls with these.

---
 rtl/cycle_sequencer_pkg.sv | 18 +
 rtl/cycle_sequencer_if.sv | 35 +++
 rtl/cycle_sequencer_beat_counter.sv | 48 ++++
 rtl/cycle_sequencer.sv | 88 ++++++++
 tb/tb_cycle_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the machine-cycle sequencer: state encodings,
// default beat limit and the length-field width helper.
package cycle_sequencer_pkg;

    localparam int T_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IF   = 2'd1,
        ST_EX   = 2'd2,
        ST_MEM  = 2'd3
    } seq_state_e;

    function automatic int len_width(input int t_max);
        return $clog2(t_max);
    endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control-unit side of the sequencer: per-instruction requests and lengths in,
// one-hot machine-cycle / beat strobes and status out.
interface cycle_sequencer_if
    import cycle_sequencer_pkg::*;
#(
    parameter int T_MAX = T_MAX_DEFAULT
);
    localparam int CW = len_width(T_MAX);

    logic             run;
    logic             stop;
    logic             stall;
    logic             need_mem;
    logic [CW-1:0]    if_len;
    logic [CW-1:0]    ex_len;
    logic [CW-1:0]    mem_len;
    logic             m_if;
    logic             m_ex;
    logic             m_mem;
    logic [T_MAX-1:0] t;
    logic             beat_last;
    logic             done;
    logic             busy;

    modport master (
        output run, stop, stall, need_mem, if_len, ex_len, mem_len,
        input  m_if, m_ex, m_mem, t, beat_last, done, busy
    );

    modport slave (
        input  run, stop, stall, need_mem, if_len, ex_len, mem_len,
        output m_if, m_ex, m_mem, t, beat_last, done, busy
    );

endinterface

// File: rtl/cycle_sequencer_beat_counter.sv
// Beat counter for one machine cycle: loads a clamped length on clr, counts up
// to it, and freezes while hold is high.
module beat_counter
    import cycle_sequencer_pkg::*;
#(
    parameter int T_MAX = T_MAX_DEFAULT,
    localparam int CW = len_width(T_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          hold,
    input  logic [CW-1:0] len,
    output logic [CW-1:0] beat,
    output logic          last
);

    localparam logic [CW-1:0] LEN_MAX = CW'(T_MAX - 1);

    logic [CW-1:0] beat_q, beat_d;
    logic [CW-1:0] len_q, len_d;

    // clr has priority so a new cycle can be loaded even while idle-held
    always_comb begin
        beat_d = beat_q;
        len_d  = len_q;
        if (clr) begin
            beat_d = '0;
            len_d  = (len > LEN_MAX) ? LEN_MAX : len;
        end else if (!hold && (beat_q != len_q)) begin
            beat_d = beat_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            len_q  <= '0;
        end else begin
            beat_q <= beat_d;
            len_q  <= len_d;
        end
    end

    assign beat = beat_q;
    assign last = (beat_q == len_q);

endmodule

// File: rtl/cycle_sequencer.sv
// Machine-cycle sequencer: walks each instruction through IF, EX and optional
// MEM with per-cycle beat counts, honouring bus stalls and clean stop requests.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int T_MAX = T_MAX_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    cycle_sequencer_if.slave bus
);

    localparam int CW = len_width(T_MAX);

    seq_state_e    state_q, state_d;
    logic          stop_pend_q, stop_pend_d;
    logic [CW-1:0] beat;
    logic [CW-1:0] len_sel;
    logic          last;
    logic          busy;
    logic          start;
    logic          cyc_end;
    logic          instr_end;

    assign busy      = (state_q != ST_IDLE);
    assign start     = (state_q == ST_IDLE) && bus.run && !bus.stop;
    assign cyc_end   = busy && last && !bus.stall;
    assign instr_end = cyc_end &&
                       ((state_q == ST_MEM) || ((state_q == ST_EX) && !bus.need_mem));

    // Length for whichever cycle is entered next; only used when clr fires
    always_comb begin
        case (state_q)
            ST_IF:   len_sel = bus.ex_len;
            ST_EX:   len_sel = bus.need_mem ? bus.mem_len : bus.if_len;
            default: len_sel = bus.if_len;
        endcase
    end

    beat_counter #(.T_MAX(T_MAX)) u_beat (
        .clk  (clk),
        .rst  (rst),
        .clr  (start || cyc_end),
        .hold (!busy || bus.stall),
        .len  (len_sel),
        .beat (beat),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_IF;
            ST_IF:   if (cyc_end) state_d = ST_EX;
            ST_EX:   if (cyc_end && bus.need_mem) state_d = ST_MEM;
            default: state_d = state_q;
        endcase
        // A stop seen at any point of the instruction only takes effect here
        if (instr_end) begin
            state_d = (bus.run && !stop_pend_q && !bus.stop) ? ST_IF : ST_IDLE;
        end
        stop_pend_d = (state_d == ST_IDLE) ? 1'b0 : (stop_pend_q || (busy && bus.stop));
    end

    always_comb begin
        bus.m_if      = (state_q == ST_IF);
        bus.m_ex      = (state_q == ST_EX);
        bus.m_mem     = (state_q == ST_MEM);
        bus.busy      = busy;
        bus.beat_last = busy && last;
        bus.done      = instr_end;
        bus.t         = '0;
        for (int i = 0; i < T_MAX; i++) begin
            bus.t[i] = busy && (beat == CW'(i));
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: two instances (T_MAX 4 and 3) share one directed
// stimulus and are checked every cycle against a beat-count model.
module tb_cycle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run, stop, stall, need_mem;
    logic [1:0] if_len, ex_len, mem_len;
    bit         chk_en = 1'b0;

    cycle_sequencer_if #(.T_MAX(4)) bus4 ();
    cycle_sequencer_if #(.T_MAX(3)) bus3 ();

    assign bus4.run = run;       assign bus3.run = run;
    assign bus4.stop = stop;     assign bus3.stop = stop;
    assign bus4.stall = stall;   assign bus3.stall = stall;
    assign bus4.need_mem = need_mem; assign bus3.need_mem = need_mem;
    assign bus4.if_len = if_len; assign bus3.if_len = if_len;
    assign bus4.ex_len = ex_len; assign bus3.ex_len = ex_len;
    assign bus4.mem_len = mem_len; assign bus3.mem_len = mem_len;

    cycle_sequencer #(.T_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    cycle_sequencer #(.T_MAX(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 fetch, 2 execute, 3 memory; pos = beats elapsed
    // in the phase, nb = number of beats the phase lasts.
    int tmx[2] = '{4, 3};
    int ph[2]  = '{0, 0};
    int pos[2] = '{0, 0};
    int nb[2]  = '{1, 1};
    bit sp[2]  = '{0, 0};

    function automatic int cl(input int len, input int tm);
        return (len > tm - 1) ? tm - 1 : len;
    endfunction

    task automatic model_step(input int k);
        int nph, npos, nnb;
        bit fin;
        if (rst) begin
            ph[k] = 0; pos[k] = 0; nb[k] = 1; sp[k] = 0;
            return;
        end
        nph = ph[k]; npos = pos[k]; nnb = nb[k]; fin = 0;
        if (ph[k] == 0) begin
            if (run && !stop) begin
                nph = 1; npos = 0; nnb = cl(int'(if_len), tmx[k]) + 1;
            end
        end else if (!stall) begin
            if (pos[k] < nb[k] - 1) begin
                npos = pos[k] + 1;
            end else begin
                npos = 0;
                case (ph[k])
                    1: begin nph = 2; nnb = cl(int'(ex_len), tmx[k]) + 1; end
                    2: if (need_mem) begin nph = 3; nnb = cl(int'(mem_len), tmx[k]) + 1; end
                       else fin = 1;
                    default: fin = 1;
                endcase
                if (fin) begin
                    if (run && !sp[k] && !stop) begin
                        nph = 1; nnb = cl(int'(if_len), tmx[k]) + 1;
                    end else begin
                        nph = 0;
                    end
                end
            end
        end
        sp[k]  = (nph == 0) ? 1'b0 : (sp[k] || (ph[k] != 0 && stop));
        ph[k]  = nph; pos[k] = npos; nb[k] = nnb;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic cmp_one(input int k, input logic mif, input logic mex, input logic mmem,
                           input logic [31:0] tt, input logic bl, input logic dn, input logic bz);
        int  et;
        bit  ebz, el, ed;
        ebz = (ph[k] != 0);
        et  = ebz ? (1 << pos[k]) : 0;
        el  = ebz && (pos[k] == nb[k] - 1);
        ed  = el && !stall && (ph[k] == 3 || (ph[k] == 2 && !need_mem));
        chk($sformatf("T%0d m_if", tmx[k]), {31'd0, mif}, int'(ph[k] == 1));
        chk($sformatf("T%0d m_ex", tmx[k]), {31'd0, mex}, int'(ph[k] == 2));
        chk($sformatf("T%0d m_mem", tmx[k]), {31'd0, mmem}, int'(ph[k] == 3));
        chk($sformatf("T%0d t", tmx[k]), tt, et);
        chk($sformatf("T%0d beat_last", tmx[k]), {31'd0, bl}, int'(el));
        chk($sformatf("T%0d done", tmx[k]), {31'd0, dn}, int'(ed));
        chk($sformatf("T%0d busy", tmx[k]), {31'd0, bz}, int'(ebz));
    endtask

    // Per-instruction measurements taken from the DUT, pinned later by literals
    int ilen4 = 0, ex3_4 = 0, ilen3 = 0, mex_3 = 0;
    int q_len4[$], q_ex3_4[$], q_len3[$], q_mex3[$];

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_one(0, bus4.m_if, bus4.m_ex, bus4.m_mem, 32'(bus4.t),
                    bus4.beat_last, bus4.done, bus4.busy);
            cmp_one(1, bus3.m_if, bus3.m_ex, bus3.m_mem, 32'(bus3.t),
                    bus3.beat_last, bus3.done, bus3.busy);
            if (bus4.busy !== 1'b1) begin
                ilen4 = 0; ex3_4 = 0;
            end else begin
                ilen4++;
                if (bus4.m_ex && bus4.t[3]) ex3_4++;
                if (bus4.done) begin
                    q_len4.push_back(ilen4); q_ex3_4.push_back(ex3_4);
                    ilen4 = 0; ex3_4 = 0;
                end
            end
            if (bus3.busy !== 1'b1) begin
                ilen3 = 0; mex_3 = 0;
            end else begin
                ilen3++;
                if (bus3.m_ex) mex_3++;
                if (bus3.done) begin
                    q_len3.push_back(ilen3); q_mex3.push_back(mex_3);
                    ilen3 = 0; mex_3 = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done4(input string what);
        bit got;
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (bus4.done === 1'b1) got = 1;
        end
        if (!got) chk({what, " timeout"}, 0, 1);
    endtask

    int exp_len[5] = '{8, 10, 11, 8, 2};
    int exp_ex3[5] = '{1, 1, 4, 0, 0};

    initial begin
        bit seen;
        rst = 1; run = 1; stop = 0; stall = 0; need_mem = 0;
        if_len = 2'd3; ex_len = 2'd3; mem_len = 2'd1;

        tick();
        chk_en = 1;
        @(negedge clk);
        chk("reset busy", {31'd0, bus4.busy}, 0);
        chk("reset t", 32'(bus4.t), 0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("reset m_if", {31'd0, bus4.m_if}, 0);
        chk("reset t3", 32'(bus3.t), 0);
        tick();
        @(negedge clk);
        chk("start m_if", {31'd0, bus4.m_if}, 1);
        chk("start t", 32'(bus4.t), 1);

        wait_done4("inst1");
        tick();
        need_mem = 1;
        @(negedge clk);
        chk("b2b1 m_if", {31'd0, bus4.m_if}, 1);
        chk("b2b1 t", 32'(bus4.t), 1);

        wait_done4("inst2");
        tick();
        need_mem = 0;
        @(negedge clk);
        chk("b2b2 m_if", {31'd0, bus4.m_if}, 1);
        chk("b2b2 t", 32'(bus4.t), 1);
        repeat (7) tick();
        stall = 1;
        repeat (3) tick();
        stall = 0;

        wait_done4("inst3");
        tick();
        ex_len = 2'd0; need_mem = 1; mem_len = 2'd2;
        tick();
        stop = 1;
        tick();
        stop = 0;
        wait_done4("inst4");
        tick();
        run = 0;
        @(negedge clk);
        chk("stop idle", {31'd0, bus4.busy}, 0);
        tick(); tick();

        if_len = 2'd1; ex_len = 2'd1; need_mem = 1; mem_len = 2'd3; run = 1;
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (bus4.m_mem === 1'b1) seen = 1;
        end
        if (!seen) chk("mem entry timeout", 0, 1);
        tick();
        rst = 1; stall = 1;
        tick();
        rst = 0; stall = 0; stop = 1;
        @(negedge clk);
        chk("rst mid-mem busy", {31'd0, bus4.busy}, 0);
        chk("rst mid-mem m_mem", {31'd0, bus4.m_mem}, 0);
        tick();
        @(negedge clk);
        chk("stop beats run", {31'd0, bus4.busy}, 0);
        tick();
        if_len = 2'd0; ex_len = 2'd0; need_mem = 0; stop = 0;
        tick();
        run = 0;
        wait_done4("inst6");
        repeat (3) tick();
        @(negedge clk);
        chk("final idle", {31'd0, bus4.busy}, 0);

        chk("T4 instr count", 32'(q_len4.size()), 5);
        for (int i = 0; i < 5 && i < q_len4.size(); i++) begin
            chk($sformatf("T4 instr%0d cycles", i + 1), 32'(q_len4[i]), exp_len[i]);
            chk($sformatf("T4 instr%0d EX t3 cycles", i + 1), 32'(q_ex3_4[i]), exp_ex3[i]);
        end
        chk("T3 instr count", {31'd0, q_len3.size() > 0}, 1);
        if (q_len3.size() > 0) begin
            chk("T3 instr1 cycles", 32'(q_len3[0]), 6);
            chk("T3 instr1 EX beats", 32'(q_mex3[0]), 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
